// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: turns a command/response handshake into pipelined SINGLE
// transfers. An address-phase register (A) feeds a data-phase register (D),
// so the address of transfer N+1 overlaps the data phase of transfer N.
// An ERROR response cancels a pending address phase for one cycle; the
// pending command is kept in A and re-issued once the error completes.
module ahb_lite_manager #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              hsel,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [ADDR_W-1:0] haddr,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic {
        A_IDLE,
        A_ACTIVE
    } a_state_t;

    typedef enum logic [1:0] {
        D_NONE,
        D_DATA,
        D_ERR2
    } d_state_t;

    a_state_t          a_state_q, a_state_d;
    logic              a_write_q, a_write_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [2:0]        a_size_q, a_size_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;

    d_state_t          d_state_q, d_state_d;
    logic              d_write_q, d_write_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              a_active;
    logic              addr_done;
    logic              cmd_accept;
    logic [ADDR_W-1:0] aligned_addr;

    assign a_active = (a_state_q == A_ACTIVE);

    // An address phase only completes while NONSEQ is actually on the bus,
    // which is never the case during the second error cycle.
    assign addr_done = a_active && hready && (d_state_q != D_ERR2);

    assign cmd_ready = !a_active
                       || (hready && (d_state_q != D_ERR2)
                           && !((d_state_q == D_DATA) && hresp));
    assign cmd_accept = cmd_valid && cmd_ready;

    // Clear the address bits below the transfer size so haddr is aligned.
    always_comb begin
        aligned_addr = cmd_addr;
        for (int i = 0; i < ADDR_W; i++) begin
            if (i < int'(cmd_size)) begin
                aligned_addr[i] = 1'b0;
            end
        end
    end

    // Next-state logic for the address register, data register and response.
    always_comb begin
        a_state_d   = a_state_q;
        a_write_d   = a_write_q;
        a_addr_d    = a_addr_q;
        a_size_d    = a_size_q;
        a_wdata_d   = a_wdata_q;
        d_state_d   = d_state_q;
        d_write_d   = d_write_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        case (d_state_q)
            D_DATA: begin
                if (hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = hresp;
                    rsp_rdata_d = (hresp || d_write_q) ? '0 : hrdata;
                    d_state_d   = D_NONE;
                end else if (hresp) begin
                    d_state_d = D_ERR2;
                end
            end
            D_ERR2: begin
                if (hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    d_state_d   = D_NONE;
                end
            end
            default: begin
            end
        endcase

        if (addr_done) begin
            d_state_d = D_DATA;
            d_write_d = a_write_q;
            hwdata_d  = a_wdata_q;
            a_state_d = A_IDLE;
        end

        if (cmd_accept) begin
            a_state_d = A_ACTIVE;
            a_write_d = cmd_write;
            a_addr_d  = aligned_addr;
            a_size_d  = cmd_size;
            a_wdata_d = cmd_wdata;
        end
    end

    // State and pipeline registers; reset drops any in-flight transfer.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_state_q   <= A_IDLE;
            a_write_q   <= 1'b0;
            a_addr_q    <= '0;
            a_size_q    <= '0;
            a_wdata_q   <= '0;
            d_state_q   <= D_NONE;
            d_write_q   <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_state_q   <= a_state_d;
            a_write_q   <= a_write_d;
            a_addr_q    <= a_addr_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            d_state_q   <= d_state_d;
            d_write_q   <= d_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign htrans    = (a_active && (d_state_q != D_ERR2)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hsel      = a_active;
    assign hwrite    = a_write_q;
    assign haddr     = a_addr_q;
    assign hsize     = a_size_q;
    assign hburst    = 3'b000;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = a_active || (d_state_q != D_NONE);

endmodule
